// File: rtl/cc_usequencer_pkg.sv
// Shared encodings for the microprogram sequencer: sequencing ops, condition
// selects and PSR flag bit positions.
package cc_usequencer_pkg;

  typedef enum logic [2:0] {
    SEQ_NEXT     = 3'd0,
    SEQ_JUMP     = 3'd1,
    SEQ_CJUMP    = 3'd2,
    SEQ_DISPATCH = 3'd3,
    SEQ_CALL     = 3'd4,
    SEQ_RET      = 3'd5,
    SEQ_WAIT     = 3'd6,
    SEQ_RSVD     = 3'd7
  } seq_e;

  typedef enum logic [2:0] {
    COND_FALSE = 3'd0,
    COND_N     = 3'd1,
    COND_Z     = 3'd2,
    COND_V     = 3'd3,
    COND_C     = 3'd4,
    COND_BIT13 = 3'd5,
    COND_TRUE  = 3'd6,
    COND_LT    = 3'd7
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

endpackage

// File: rtl/cc_usequencer_if.sv
// Microword / status bundle between the control store side and the sequencer.
interface cc_usequencer_if #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned DISPATCH_W = 8,
  parameter int unsigned FLAG_W     = 4,
  parameter int unsigned DEPTH_W    = 3
);
  logic [2:0]            cc_usequencer_Seq_InBUS;
  logic [2:0]            cc_usequencer_Cond_InBUS;
  logic [ADDR_W-1:0]     cc_usequencer_JumpAddr_InBUS;
  logic [DISPATCH_W-1:0] cc_usequencer_Dispatch_InBUS;
  logic                  cc_usequencer_Bit13_In;
  logic [FLAG_W-1:0]     cc_usequencer_Flags_InBUS;
  logic                  cc_usequencer_SetCond_In;
  logic                  cc_usequencer_ACK_In;
  logic [ADDR_W-1:0]     cc_usequencer_Addr_OutBUS;
  logic [FLAG_W-1:0]     cc_usequencer_Flags_OutBUS;
  logic                  cc_usequencer_Waiting_Out;
  logic [DEPTH_W-1:0]    cc_usequencer_Depth_OutBUS;
  logic                  cc_usequencer_StackErr_Out;

  modport master (
    output cc_usequencer_Seq_InBUS, cc_usequencer_Cond_InBUS, cc_usequencer_JumpAddr_InBUS,
           cc_usequencer_Dispatch_InBUS, cc_usequencer_Bit13_In, cc_usequencer_Flags_InBUS,
           cc_usequencer_SetCond_In, cc_usequencer_ACK_In,
    input  cc_usequencer_Addr_OutBUS, cc_usequencer_Flags_OutBUS, cc_usequencer_Waiting_Out,
           cc_usequencer_Depth_OutBUS, cc_usequencer_StackErr_Out
  );

  modport slave (
    input  cc_usequencer_Seq_InBUS, cc_usequencer_Cond_InBUS, cc_usequencer_JumpAddr_InBUS,
           cc_usequencer_Dispatch_InBUS, cc_usequencer_Bit13_In, cc_usequencer_Flags_InBUS,
           cc_usequencer_SetCond_In, cc_usequencer_ACK_In,
    output cc_usequencer_Addr_OutBUS, cc_usequencer_Flags_OutBUS, cc_usequencer_Waiting_Out,
           cc_usequencer_Depth_OutBUS, cc_usequencer_StackErr_Out
  );
endinterface

// File: rtl/cc_ustack.sv
// Return-address LIFO with a registered occupancy counter. Overflowing pushes
// and underflowing pops are ignored; the caller decides how to flag them.
module cc_ustack #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DATA_W  = 11,
  parameter int unsigned DEPTH_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] top_data_c,
  output logic              full_c,
  output logic              empty_c,
  output logic [DEPTH_W-1:0] depth
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DEPTH_W-1:0] depth_q;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic               push_ok;
  logic               pop_ok;

  assign full_c  = (depth_q == DEPTH_W'(DEPTH));
  assign empty_c = (depth_q == '0);
  assign push_ok = push & ~full_c;
  assign pop_ok  = pop & ~empty_c;
  assign wr_idx  = IDX_W'(depth_q);
  assign rd_idx  = IDX_W'(depth_q - DEPTH_W'(1));
  assign top_data_c = mem[rd_idx];
  assign depth   = depth_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q <= '0;
    end else if (push_ok) begin
      depth_q <= depth_q + DEPTH_W'(1);
    end else if (pop_ok) begin
      depth_q <= depth_q - DEPTH_W'(1);
    end
  end

  // Contents are don't-care after reset, so the storage carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/cc_usequencer.sv
// Microprogram sequencer: registered micro-PC and PSR, branch evaluation,
// subroutine call/return via cc_ustack, and a WAIT stall on memory ACK.
module cc_usequencer
  import cc_usequencer_pkg::*;
#(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned DISPATCH_W  = 8,
  parameter int unsigned FLAG_W      = 4,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned DEPTH_W     = 3
) (
  input  logic cc_usequencer_CLOCK_50,
  input  logic cc_usequencer_RESET_InHigh,
  cc_usequencer_if.slave bus
);
  localparam int unsigned PAD_W = ADDR_W - DISPATCH_W - 1;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] incr_c;
  logic [ADDR_W-1:0] disp_c;
  logic [ADDR_W-1:0] top_c;
  logic [FLAG_W-1:0] psr_q;
  logic              err_q;
  logic              err_set_c;
  logic              cond_c;
  logic              push_c;
  logic              pop_c;
  logic              full_c;
  logic              empty_c;
  logic              ack;
  seq_e              seq;
  cond_e             cond;

  assign seq    = seq_e'(bus.cc_usequencer_Seq_InBUS);
  assign cond   = cond_e'(bus.cc_usequencer_Cond_InBUS);
  assign ack    = bus.cc_usequencer_ACK_In;
  assign incr_c = addr_q + ADDR_W'(1);
  assign disp_c = (ADDR_W'(1) << (ADDR_W - 1))
                | (ADDR_W'(bus.cc_usequencer_Dispatch_InBUS) << PAD_W);

  // Branch conditions always look at the PSR as it stood before this edge.
  always_comb begin
    cond_c = 1'b0;
    case (cond)
      COND_FALSE: cond_c = 1'b0;
      COND_N:     cond_c = psr_q[FLAG_N];
      COND_Z:     cond_c = psr_q[FLAG_Z];
      COND_V:     cond_c = psr_q[FLAG_V];
      COND_C:     cond_c = psr_q[FLAG_C];
      COND_BIT13: cond_c = bus.cc_usequencer_Bit13_In;
      COND_TRUE:  cond_c = 1'b1;
      COND_LT:    cond_c = psr_q[FLAG_N] ^ psr_q[FLAG_V];
      default:    cond_c = 1'b0;
    endcase
  end

  always_comb begin
    addr_d    = incr_c;
    push_c    = 1'b0;
    pop_c     = 1'b0;
    err_set_c = 1'b0;
    case (seq)
      SEQ_NEXT:     addr_d = incr_c;
      SEQ_JUMP:     addr_d = bus.cc_usequencer_JumpAddr_InBUS;
      SEQ_CJUMP:    addr_d = cond_c ? bus.cc_usequencer_JumpAddr_InBUS : incr_c;
      SEQ_DISPATCH: addr_d = disp_c;
      SEQ_CALL: begin
        addr_d = bus.cc_usequencer_JumpAddr_InBUS;
        if (full_c) err_set_c = 1'b1;
        else        push_c    = 1'b1;
      end
      SEQ_RET: begin
        if (empty_c) begin
          addr_d    = '0;
          err_set_c = 1'b1;
        end else begin
          addr_d = top_c;
          pop_c  = 1'b1;
        end
      end
      SEQ_WAIT:     addr_d = ack ? incr_c : addr_q;
      SEQ_RSVD:     addr_d = incr_c;
      default:      addr_d = incr_c;
    endcase
  end

  always_ff @(posedge cc_usequencer_CLOCK_50 or posedge cc_usequencer_RESET_InHigh) begin
    if (cc_usequencer_RESET_InHigh) begin
      addr_q <= '0;
      psr_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      if (bus.cc_usequencer_SetCond_In) psr_q <= bus.cc_usequencer_Flags_InBUS;
      if (err_set_c) err_q <= 1'b1;
    end
  end

  cc_ustack #(
    .DEPTH   (STACK_DEPTH),
    .DATA_W  (ADDR_W),
    .DEPTH_W (DEPTH_W)
  ) u_stack (
    .clk        (cc_usequencer_CLOCK_50),
    .rst        (cc_usequencer_RESET_InHigh),
    .push       (push_c),
    .pop        (pop_c),
    .push_data  (incr_c),
    .top_data_c (top_c),
    .full_c     (full_c),
    .empty_c    (empty_c),
    .depth      (bus.cc_usequencer_Depth_OutBUS)
  );

  assign bus.cc_usequencer_Addr_OutBUS  = addr_q;
  assign bus.cc_usequencer_Flags_OutBUS = psr_q;
  assign bus.cc_usequencer_StackErr_Out = err_q;
  assign bus.cc_usequencer_Waiting_Out  = (seq == SEQ_WAIT) & ~ack;

endmodule

// File: tb/tb_cc_usequencer.sv
// Directed vector bench for cc_usequencer: one continuous microinstruction
// stream from reset, then an asynchronous reset landing in the middle of WAIT.
module tb_cc_usequencer;
  import cc_usequencer_pkg::*;

  localparam int unsigned ADDR_W      = 11;
  localparam int unsigned DISPATCH_W  = 8;
  localparam int unsigned FLAG_W      = 4;
  localparam int unsigned STACK_DEPTH = 4;
  localparam int unsigned DEPTH_W     = 3;
  localparam int unsigned NVEC        = 34;

  typedef struct {
    logic [2:0]            seq;
    logic [2:0]            cond;
    logic [ADDR_W-1:0]     jump;
    logic [DISPATCH_W-1:0] disp;
    logic                  bit13;
    logic [FLAG_W-1:0]     flags;
    logic                  setc;
    logic                  ack;
    logic [ADDR_W-1:0]     e_addr;
    logic [FLAG_W-1:0]     e_flags;
    logic [DEPTH_W-1:0]    e_depth;
    logic                  e_err;
    logic                  e_wait;
  } vec_t;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  vec_t vt [NVEC];

  cc_usequencer_if #(
    .ADDR_W(ADDR_W), .DISPATCH_W(DISPATCH_W), .FLAG_W(FLAG_W), .DEPTH_W(DEPTH_W)
  ) bus ();

  cc_usequencer #(
    .ADDR_W(ADDR_W), .DISPATCH_W(DISPATCH_W), .FLAG_W(FLAG_W),
    .STACK_DEPTH(STACK_DEPTH), .DEPTH_W(DEPTH_W)
  ) dut (
    .cc_usequencer_CLOCK_50     (clk),
    .cc_usequencer_RESET_InHigh (rst),
    .bus                        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [2:0] seq, input logic [2:0] cond,
                              input logic [ADDR_W-1:0] jump, input logic [DISPATCH_W-1:0] disp,
                              input logic bit13, input logic [FLAG_W-1:0] flags,
                              input logic setc, input logic ack,
                              input logic [ADDR_W-1:0] e_addr, input logic [FLAG_W-1:0] e_flags,
                              input logic [DEPTH_W-1:0] e_depth, input logic e_err,
                              input logic e_wait);
    vec_t v;
    v.seq = seq; v.cond = cond; v.jump = jump; v.disp = disp; v.bit13 = bit13;
    v.flags = flags; v.setc = setc; v.ack = ack; v.e_addr = e_addr; v.e_flags = e_flags;
    v.e_depth = e_depth; v.e_err = e_err; v.e_wait = e_wait;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s vec=%0d actual=0x%0h required=0x%0h", name, idx, act, exp);
  endtask

  task automatic drive(input vec_t v);
    bus.cc_usequencer_Seq_InBUS      = v.seq;
    bus.cc_usequencer_Cond_InBUS     = v.cond;
    bus.cc_usequencer_JumpAddr_InBUS = v.jump;
    bus.cc_usequencer_Dispatch_InBUS = v.disp;
    bus.cc_usequencer_Bit13_In       = v.bit13;
    bus.cc_usequencer_Flags_InBUS    = v.flags;
    bus.cc_usequencer_SetCond_In     = v.setc;
    bus.cc_usequencer_ACK_In         = v.ack;
  endtask

  task automatic check_state(input int idx, input logic [ADDR_W-1:0] a,
                             input logic [FLAG_W-1:0] f, input logic [DEPTH_W-1:0] d,
                             input logic e);
    check("addr",  idx, 32'(bus.cc_usequencer_Addr_OutBUS),  32'(a));
    check("flags", idx, 32'(bus.cc_usequencer_Flags_OutBUS), 32'(f));
    check("depth", idx, 32'(bus.cc_usequencer_Depth_OutBUS), 32'(d));
    check("err",   idx, 32'(bus.cc_usequencer_StackErr_Out), 32'(e));
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    //          seq cond jump    disp   b13 flags  sc ack  addr    flg    d  e  w
    vt[0]  = mk(3'd0, 3'd0, 11'h000, 8'h00, 0, 4'h0, 0, 0, 11'h001, 4'h0, 0, 0, 0);
    vt[1]  = mk(3'd0, 3'd0, 11'h000, 8'h00, 0, 4'h0, 0, 0, 11'h002, 4'h0, 0, 0, 0);
    vt[2]  = mk(3'd0, 3'd0, 11'h000, 8'h00, 0, 4'h0, 0, 0, 11'h003, 4'h0, 0, 0, 0);
    vt[3]  = mk(3'd1, 3'd0, 11'h7FF, 8'h00, 0, 4'h0, 0, 0, 11'h7FF, 4'h0, 0, 0, 0);
    vt[4]  = mk(3'd0, 3'd0, 11'h000, 8'h00, 0, 4'h0, 0, 0, 11'h000, 4'h0, 0, 0, 0);
    vt[5]  = mk(3'd3, 3'd0, 11'h000, 8'hA5, 0, 4'h0, 0, 0, 11'h694, 4'h0, 0, 0, 0);
    vt[6]  = mk(3'd1, 3'd0, 11'h050, 8'h00, 0, 4'h0, 0, 0, 11'h050, 4'h0, 0, 0, 0);
    // SetCond with CJUMP on Z in the same cycle: branch sees the old Z=0
    vt[7]  = mk(3'd2, 3'd2, 11'h100, 8'h00, 0, 4'h4, 1, 0, 11'h051, 4'h4, 0, 0, 0);
    vt[8]  = mk(3'd2, 3'd2, 11'h100, 8'h00, 0, 4'h0, 0, 0, 11'h100, 4'h4, 0, 0, 0);
    vt[9]  = mk(3'd2, 3'd3, 11'h200, 8'h00, 0, 4'h8, 1, 0, 11'h101, 4'h8, 0, 0, 0);
    vt[10] = mk(3'd2, 3'd7, 11'h120, 8'h00, 0, 4'h0, 0, 0, 11'h120, 4'h8, 0, 0, 0);
    vt[11] = mk(3'd2, 3'd5, 11'h130, 8'h00, 1, 4'h0, 0, 0, 11'h130, 4'h8, 0, 0, 0);
    vt[12] = mk(3'd2, 3'd0, 11'h200, 8'h00, 1, 4'h0, 0, 0, 11'h131, 4'h8, 0, 0, 0);
    vt[13] = mk(3'd2, 3'd4, 11'h200, 8'h00, 0, 4'h1, 1, 0, 11'h132, 4'h1, 0, 0, 0);
    vt[14] = mk(3'd2, 3'd4, 11'h140, 8'h00, 0, 4'h0, 0, 0, 11'h140, 4'h1, 0, 0, 0);
    vt[15] = mk(3'd7, 3'd6, 11'h300, 8'h00, 0, 4'h0, 0, 0, 11'h141, 4'h1, 0, 0, 0);
    vt[16] = mk(3'd1, 3'd0, 11'h010, 8'h00, 0, 4'h0, 0, 0, 11'h010, 4'h1, 0, 0, 0);
    vt[17] = mk(3'd4, 3'd0, 11'h200, 8'h00, 0, 4'h0, 0, 0, 11'h200, 4'h1, 1, 0, 0);
    vt[18] = mk(3'd5, 3'd0, 11'h000, 8'h00, 0, 4'h0, 0, 0, 11'h011, 4'h1, 0, 0, 0);
    vt[19] = mk(3'd1, 3'd0, 11'h030, 8'h00, 0, 4'h0, 0, 0, 11'h030, 4'h1, 0, 0, 0);
    // WAIT holds the micro-PC but still lets the PSR load
    vt[20] = mk(3'd6, 3'd0, 11'h000, 8'h00, 0, 4'h0, 0, 0, 11'h030, 4'h1, 0, 0, 1);
    vt[21] = mk(3'd6, 3'd6, 11'h3FF, 8'h00, 0, 4'h6, 1, 0, 11'h030, 4'h6, 0, 0, 1);
    vt[22] = mk(3'd6, 3'd0, 11'h000, 8'h00, 0, 4'h0, 0, 0, 11'h030, 4'h6, 0, 0, 1);
    vt[23] = mk(3'd6, 3'd0, 11'h000, 8'h00, 0, 4'h0, 0, 1, 11'h031, 4'h6, 0, 0, 0);
    vt[24] = mk(3'd4, 3'd0, 11'h300, 8'h00, 0, 4'h0, 0, 0, 11'h300, 4'h6, 1, 0, 0);
    vt[25] = mk(3'd4, 3'd0, 11'h310, 8'h00, 0, 4'h0, 0, 0, 11'h310, 4'h6, 2, 0, 0);
    vt[26] = mk(3'd4, 3'd0, 11'h320, 8'h00, 0, 4'h0, 0, 0, 11'h320, 4'h6, 3, 0, 0);
    vt[27] = mk(3'd4, 3'd0, 11'h330, 8'h00, 0, 4'h0, 0, 0, 11'h330, 4'h6, 4, 0, 0);
    vt[28] = mk(3'd4, 3'd0, 11'h340, 8'h00, 0, 4'h0, 0, 0, 11'h340, 4'h6, 4, 1, 0);
    vt[29] = mk(3'd5, 3'd0, 11'h000, 8'h00, 0, 4'h0, 0, 0, 11'h321, 4'h6, 3, 1, 0);
    vt[30] = mk(3'd5, 3'd0, 11'h000, 8'h00, 0, 4'h0, 0, 0, 11'h311, 4'h6, 2, 1, 0);
    vt[31] = mk(3'd5, 3'd0, 11'h000, 8'h00, 0, 4'h0, 0, 0, 11'h301, 4'h6, 1, 1, 0);
    vt[32] = mk(3'd5, 3'd0, 11'h000, 8'h00, 0, 4'h0, 0, 0, 11'h032, 4'h6, 0, 1, 0);
    vt[33] = mk(3'd5, 3'd0, 11'h000, 8'h00, 0, 4'h0, 0, 0, 11'h000, 4'h6, 0, 1, 0);

    drive(mk(3'd0, 3'd0, 11'h0, 8'h0, 0, 4'h0, 0, 0, 11'h0, 4'h0, 0, 0, 0));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_state(-1, 11'h000, 4'h0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < int'(NVEC); i++) begin
      drive(vt[i]);
      #1;
      check("waiting", i, 32'(bus.cc_usequencer_Waiting_Out), 32'(vt[i].e_wait));
      @(posedge clk);
      #1;
      check_state(i, vt[i].e_addr, vt[i].e_flags, vt[i].e_depth, vt[i].e_err);
      @(negedge clk);
    end

    // Asynchronous reset landing mid-WAIT with a live call frame
    drive(mk(3'd4, 3'd0, 11'h030, 8'h0, 0, 4'h9, 1, 0, 11'h0, 4'h0, 0, 0, 0));
    @(posedge clk);
    #1;
    check_state(100, 11'h030, 4'h9, 1, 1'b1);
    @(negedge clk);
    drive(mk(3'd6, 3'd0, 11'h000, 8'h0, 0, 4'h0, 0, 0, 11'h0, 4'h0, 0, 0, 0));
    @(posedge clk);
    #1;
    check_state(101, 11'h030, 4'h9, 1, 1'b1);
    check("waiting", 101, 32'(bus.cc_usequencer_Waiting_Out), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_state(102, 11'h000, 4'h0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(mk(3'd0, 3'd0, 11'h000, 8'h0, 0, 4'h0, 0, 0, 11'h0, 4'h0, 0, 0, 0));
    @(posedge clk);
    #1;
    check_state(103, 11'h001, 4'h0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cc_usequencer.md
Name: cc_usequencer

Overview:
Parametrised microprogram sequencer for the microcoded control unit. It is the successor to the fixed address-increment / address-mux / branch-logic / PSR cluster.
- Holds the registered micro-PC and a PSR flag register.
- Evaluates branch conditions and drives the control-store (ROM) address.
- New over the previous generation: microcode subroutine call/return (a return stack), a WAIT mode that stalls on the memory ACK, and generic address, dispatch and stack widths.

Parameters:
ADDR_W, 11, micro-PC / control-store address width
DISPATCH_W, 8, IR dispatch field width ({op, op3}); requires ADDR_W >= DISPATCH_W+1
FLAG_W, 4, PSR width, bit order {N,Z,V,C}
STACK_DEPTH, 4, return-stack entries (>=1)
DEPTH_W, 3, width of depth output; must hold STACK_DEPTH

Ports:
cc_usequencer_CLOCK_50  in  1  clock, rising edge
cc_usequencer_RESET_InHigh  in  1  asynchronous active-high reset
cc_usequencer_Seq_InBUS  in  3  microword sequencing op
cc_usequencer_Cond_InBUS  in  3  microword condition select
cc_usequencer_JumpAddr_InBUS  in  ADDR_W  microword jump address
cc_usequencer_Dispatch_InBUS  in  DISPATCH_W  IR {op,op3}
cc_usequencer_Bit13_In  in  1  IR bit 13
cc_usequencer_Flags_InBUS  in  FLAG_W  ALU flags {N,Z,V,C}
cc_usequencer_SetCond_In  in  1  load PSR from Flags_InBUS
cc_usequencer_ACK_In  in  1  main-memory acknowledge
cc_usequencer_Addr_OutBUS  out  ADDR_W  registered micro-PC to ROM
cc_usequencer_Flags_OutBUS  out  FLAG_W  registered PSR
cc_usequencer_Waiting_Out  out  1  combinational stall indicator
cc_usequencer_Depth_OutBUS  out  DEPTH_W  return-stack occupancy
cc_usequencer_StackErr_Out  out  1  sticky stack overflow/underflow

Behaviour:
- Reset (async, immediate):
  - Addr=0, PSR=0, Depth=0, StackErr=0; stack contents don't-care.
  - Reset mid-WAIT or mid-call abandons the operation.
- Microword inputs are combinational from ROM(Addr_OutBUS) in the same cycle; the next address is registered at the rising edge (1-cycle latency per microinstruction).
- Condition select, evaluated on the registered PSR (pre-update value):
  - 0 false, 1 N, 2 Z, 3 V, 4 C, 5 Bit13_In, 6 true, 7 N^V (signed less-than).
- Seq ops (incr = Addr+1 mod 2^ADDR_W; all-ones wraps to 0):
  - 0 NEXT: incr
  - 1 JUMP: JumpAddr
  - 2 CJUMP: cond ? JumpAddr : incr
  - 3 DISPATCH: {1'b1, Dispatch, zeros padded to ADDR_W}
  - 4 CALL: push incr, go to JumpAddr
  - 5 RET: pop, go to popped value
  - 6 WAIT: ACK ? incr : hold Addr
  - 7 reserved: behaves as NEXT
- Waiting_Out = (Seq==6) & !ACK_In.
- PSR:
  - Loads Flags_InBUS at the edge when SetCond_In=1, independent of Seq; holds otherwise.
  - A SetCond and a CJUMP in the same cycle: the branch uses the old PSR.
- Stack is LIFO, Depth in 0..STACK_DEPTH.
  - CALL when full: jump still taken, no push, Depth unchanged, StackErr<=1.
  - RET when empty: Addr<=0, Depth stays 0, StackErr<=1.
  - StackErr clears only on reset.
- No state machine beyond the micro-PC; WAIT is the only stall state, and it holds all state except the PSR.

Decomposition:
- Shared package cc_usequencer_pkg holds:
  - SEQ_* op encodings (NEXT..RSVD)
  - COND_* select encodings
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_V=1, FLAG_C=0)
- One natural sub-module: cc_ustack, a parametrised LIFO with push/pop/full/empty and a registered depth counter, instantiated once.

Test Plan:
- Reset to Addr=0; NEXT x3 -> Addr 1,2,3. Force Addr=2047, NEXT -> Addr wraps to 0.
- Dispatch=8'hA5, Seq=DISPATCH -> Addr=11'b1_10100101_00 (0x694).
- SetCond=1, Flags=4'b0100 at cycle n, with CJUMP cond=Z, JumpAddr=0x100 in the same cycle -> no jump (old Z=0). Repeat next cycle -> Addr=0x100.
- From Addr=0x10, CALL 0x200 -> Addr=0x200, Depth=1. RET -> Addr=0x11, Depth=0.
- 5 nested CALLs with STACK_DEPTH=4:
  - Depth saturates at 4 and StackErr=1 after the 5th.
  - 4 RETs unwind correctly.
  - 5th RET -> Addr=0, StackErr stays 1.
- WAIT at Addr=0x30, ACK low 3 cycles -> Addr holds 0x30 and Waiting=1. ACK high -> Addr=0x31, Waiting=0. Async reset asserted mid-WAIT -> Addr=0 immediately.
